// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: valid/ready command stream in, pipelined
// NONSEQ/SINGLE/word transfers out, one in-order response per command.
module ahb_lite_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } htrans_e;

  logic              a_vld_q,   a_vld_d;
  logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
  logic              a_write_q, a_write_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  logic              d_vld_q,   d_vld_d;
  logic              d_write_q, d_write_d;
  logic [DATA_W-1:0] hwdata_q,  hwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              accept;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

  // An empty address slot may load even while the data phase is stalled.
  assign cmd_ready = !a_vld_q || HREADY;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    a_vld_d     = a_vld_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_wdata_d   = a_wdata_q;
    d_vld_d     = d_vld_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    if (HREADY) begin
      if (d_vld_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = d_write_q;
        rsp_err_d   = HRESP;
        rsp_rdata_d = d_write_q ? '0 : HRDATA;
      end
      d_vld_d   = a_vld_q;
      d_write_d = a_write_q;
      if (a_vld_q) begin
        hwdata_d = a_wdata_q;
      end
      a_vld_d = 1'b0;
    end

    if (accept) begin
      a_vld_d   = 1'b1;
      a_addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
      a_write_d = cmd_write;
      a_wdata_d = cmd_wdata;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_vld_q     <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_wdata_q   <= '0;
      d_vld_q     <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_wdata_q   <= a_wdata_d;
      d_vld_q     <= d_vld_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign HTRANS    = a_vld_q ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HWDATA    = hwdata_q;
  assign busy      = a_vld_q || d_vld_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: each task drives one scenario cycle by
// cycle and compares outputs against hand-computed values.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  // Advance into the next cycle; inputs are then driven and outputs sampled mid-cycle.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    cmd(1'b0, 1'b0, '0, '0);
    cyc(); cyc(); #1;
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
    checks++; if (HWRITE !== 1'b0) begin errors++; $display("FAIL rst_hwrite: got %b want 0", HWRITE); end
    checks++; if (HWDATA !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b000) begin errors++; $display("FAIL rst_rsp: got %b want 000", {rsp_valid, rsp_write, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
    checks++; if (HSIZE !== 3'b010 || HBURST !== 3'b000) begin errors++; $display("FAIL rst_size_burst: got %b/%b want 010/000", HSIZE, HBURST); end
    HRESETn = 1'b1;
    cyc(); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    cyc(); cmd(1'b1, 1'b1, 32'h0001_0004, 32'hDEAD_BEEF); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", cmd_ready); end
    cyc(); cmd(1'b0, 1'b0, '0, '0); #1;
    checks++; if (HTRANS !== 2'b10) begin errors++; $display("FAIL wr_htrans: got %h want 2", HTRANS); end
    checks++; if (HADDR !== 32'h0001_0004) begin errors++; $display("FAIL wr_haddr: got %h want 00010004", HADDR); end
    checks++; if (HWRITE !== 1'b1) begin errors++; $display("FAIL wr_hwrite: got %b want 1", HWRITE); end
    cyc(); #1;
    checks++; if (HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_hwdata: got %h want deadbeef", HWDATA); end
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL wr_idle: got %h want 0", HTRANS); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_dphase: got busy=%b rsp_valid=%b want 1/0", busy, rsp_valid); end
    cyc(); #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin errors++; $display("FAIL wr_rsp: got %b want 110", {rsp_valid, rsp_write, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    cyc(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_single_read();
    cyc(); cmd(1'b1, 1'b0, 32'h0000_0013, 32'h0); #1;
    cyc(); cmd(1'b0, 1'b0, '0, '0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0010 || HWRITE !== 1'b0) begin errors++; $display("FAIL rd_aphase: got %h/%h/%b want 2/00000010/0", HTRANS, HADDR, HWRITE); end
    cyc(); HRDATA = 32'h1234_5678; #1;
    cyc(); HRDATA = '0; #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100) begin errors++; $display("FAIL rd_rsp: got %b want 100", {rsp_valid, rsp_write, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata); end
    cyc(); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata_hold: got %h want 12345678", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr [4];
    logic [31:0] wd   [4];
    logic [31:0] rd   [4];
    logic        wr   [4];
    for (int i = 0; i < 4; i++) begin
      addr[i] = 32'h0000_0100 + 32'(4 * i);
      wd[i]   = 32'hA000_0000 + 32'(i);
      rd[i]   = 32'hB000_0000 + 32'(i);
      wr[i]   = (i % 2) == 0;
    end
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k < 4) cmd(1'b1, wr[k], addr[k], wd[k]);
      else       cmd(1'b0, 1'b0, '0, '0);
      HRDATA = (k >= 2 && k <= 5 && !wr[k-2]) ? rd[k-2] : 32'h0;
      #1;
      if (k < 4) begin
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, cmd_ready); end
      end
      if (k >= 1 && k <= 4) begin
        checks++; if (HTRANS !== 2'b10 || HADDR !== addr[k-1] || HWRITE !== wr[k-1]) begin errors++; $display("FAIL b2b_aphase[%0d]: got %h/%h/%b want 2/%h/%b", k, HTRANS, HADDR, HWRITE, addr[k-1], wr[k-1]); end
      end
      if (k >= 2 && k <= 5 && wr[k-2]) begin
        checks++; if (HWDATA !== wd[k-2]) begin errors++; $display("FAIL b2b_hwdata[%0d]: got %h want %h", k, HWDATA, wd[k-2]); end
      end
      if (k >= 3 && k <= 6) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_write !== wr[k-3] || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_rsp[%0d]: got %b%b%b want 1%b0", k, rsp_valid, rsp_write, rsp_err, wr[k-3]); end
        checks++; if (rsp_rdata !== (wr[k-3] ? 32'h0 : rd[k-3])) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rsp_rdata, wr[k-3] ? 32'h0 : rd[k-3]); end
      end
      if (k == 7) begin
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
      end
    end
  endtask

  task automatic test_wait_states();
    cyc(); cmd(1'b1, 1'b1, 32'h0000_0200, 32'h5555_AAAA); #1;
    cyc(); cmd(1'b1, 1'b0, 32'h0000_0204, 32'h0); #1;
    for (int k = 0; k < 3; k++) begin
      cyc(); cmd(1'b0, 1'b0, '0, '0); HREADY = 1'b0; #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ws_ready[%0d]: got %b want 0", k, cmd_ready); end
      checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0204 || HWRITE !== 1'b0) begin errors++; $display("FAIL ws_aphase[%0d]: got %h/%h/%b want 2/00000204/0", k, HTRANS, HADDR, HWRITE); end
      checks++; if (HWDATA !== 32'h5555_AAAA) begin errors++; $display("FAIL ws_hwdata[%0d]: got %h want 5555aaaa", k, HWDATA); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ws_rsp[%0d]: got %b want 0", k, rsp_valid); end
    end
    cyc(); HREADY = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b1 || HADDR !== 32'h0000_0204 || HWDATA !== 32'h5555_AAAA) begin errors++; $display("FAIL ws_release: got %b/%h/%h want 1/00000204/5555aaaa", cmd_ready, HADDR, HWDATA); end
    cyc(); HRDATA = 32'hCAFE_F00D; #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110) begin errors++; $display("FAIL ws_rsp_wr: got %b want 110", {rsp_valid, rsp_write, rsp_err}); end
    checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL ws_idle: got %h want 0", HTRANS); end
    cyc(); HRDATA = '0; #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100 || rsp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_rsp_rd: got %b %h want 100 cafef00d", {rsp_valid, rsp_write, rsp_err}, rsp_rdata); end
  endtask

  task automatic test_error();
    cyc(); cmd(1'b1, 1'b0, 32'h0000_0300, 32'h0); #1;
    cyc(); cmd(1'b1, 1'b1, 32'h0000_0304, 32'h1111_2222); #1;
    cyc(); cmd(1'b0, 1'b0, '0, '0); HREADY = 1'b0; HRESP = 1'b1; #1;
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_wait: got ready=%b rsp_valid=%b want 0/0", cmd_ready, rsp_valid); end
    cyc(); HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'h0BAD_BAD0; #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0304 || HWRITE !== 1'b1) begin errors++; $display("FAIL err_pending: got %h/%h/%b want 2/00000304/1", HTRANS, HADDR, HWRITE); end
    cyc(); HRESP = 1'b0; HRDATA = '0; #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b101) begin errors++; $display("FAIL err_rsp: got %b want 101", {rsp_valid, rsp_write, rsp_err}); end
    checks++; if (rsp_rdata !== 32'h0BAD_BAD0) begin errors++; $display("FAIL err_rdata: got %h want 0badbad0", rsp_rdata); end
    checks++; if (HWDATA !== 32'h1111_2222) begin errors++; $display("FAIL err_next_hwdata: got %h want 11112222", HWDATA); end
    cyc(); #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_next_rsp: got %b %h want 110 0", {rsp_valid, rsp_write, rsp_err}, rsp_rdata); end
  endtask

  task automatic test_reset_mid();
    cyc(); cmd(1'b1, 1'b1, 32'h0000_0400, 32'h0000_0077); #1;
    cyc(); cmd(1'b0, 1'b0, '0, '0); #1;
    cyc(); HREADY = 1'b0; HRESETn = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got %b want 1", busy); end
    cyc(); HREADY = 1'b1; HRESETn = 1'b1; #1;
    checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rm_cleared: got %h/%h/%b want 0/0/0", HTRANS, HADDR, busy); end
    checks++; if (rsp_valid !== 1'b0 || HWDATA !== 32'h0) begin errors++; $display("FAIL rm_rsp: got rsp_valid=%b hwdata=%h want 0/0", rsp_valid, HWDATA); end
    cyc(); cmd(1'b1, 1'b0, 32'h0000_0408, 32'h0); #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_no_rsp: got rsp_valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
    cyc(); cmd(1'b0, 1'b0, '0, '0); #1;
    checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0408) begin errors++; $display("FAIL rm_aphase: got %h/%h want 2/00000408", HTRANS, HADDR); end
    cyc(); HRDATA = 32'h0000_9ABC; #1;
    cyc(); HRDATA = '0; #1;
    checks++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL rm_rsp_rd: got %b %h want 100 00009abc", {rsp_valid, rsp_write, rsp_err}, rsp_rdata); end
    cyc(); #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_end: got %b/%b want 0/0", rsp_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-master AHB-Lite initiator: converts a simple valid/ready command stream into pipelined AHB-Lite single transfers (NONSEQ, SINGLE, word) and returns one response per command.
- Drives the HADDR/HWRITE/HWDATA bus that feeds our decoder, mux and slave set (ROM, RAM, GPIO, timer); samples HRDATA/HREADY/HRESP.
- Address phase of transfer N+1 overlaps data phase of transfer N, giving one transfer per cycle with zero wait states.

Parameters:
- ADDR_W, 32, HADDR and cmd_addr width.
- DATA_W, 32, HWDATA, HRDATA, cmd_wdata and rsp_rdata width; only 32 is supported.

Ports:
- HCLK  in  1  clock, all logic on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at an edge.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address, word aligned (bits[1:0] ignored, driven 0).
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_write  out  1  echo of completed transfer direction.
- rsp_rdata  out  DATA_W  HRDATA captured for reads; 0 for writes.
- rsp_err  out  1  completed transfer got ERROR.
- busy  out  1  address or data phase outstanding.
- HADDR  out  ADDR_W  address-phase address.
- HWRITE  out  1  address-phase direction.
- HTRANS  out  2  IDLE=2'b00 / NONSEQ=2'b10.
- HSIZE  out  3  constant 3'b010.
- HBURST  out  3  constant 3'b000.
- HWDATA  out  DATA_W  data-phase write data.
- HRDATA  in  DATA_W  read data.
- HREADY  in  1  transfer completion / phase advance (tie 1 on fabrics without wait states).
- HRESP  in  1  0=OKAY, 1=ERROR.

Behaviour:
- Registers: address-phase slot (a_vld, a_addr, a_write, a_wdata); data-phase slot (d_vld, d_write, HWDATA).
- HTRANS=NONSEQ iff a_vld, else IDLE; HADDR/HWRITE come from the address slot and are held stable while a_vld && !HREADY.
- cmd_ready = !a_vld || HREADY (combinational). Loading an address while the data phase is stalled is legal, because IDLE->NONSEQ during wait states is allowed.
- Edge with HREADY=1:
  - the data slot completes if d_vld;
  - d_vld<=a_vld, d_write<=a_write, HWDATA<=a_wdata (when a_vld);
  - the address slot loads the accepted command, or clears a_vld.
- Edge with HREADY=0: the data slot holds and HWDATA is stable. The address slot loads only if it was empty.
- Completion (d_vld && HREADY at edge): next cycle rsp_valid=1, rsp_write=d_write, rsp_err=HRESP, rsp_rdata=HRDATA if read else 0. Otherwise rsp_valid=0; rsp_rdata/rsp_err hold their last value.
- Latency: accept at edge T -> NONSEQ in cycle T+1 -> data phase T+2 -> rsp_valid in cycle T+3 (zero wait states). Each wait state adds one cycle.
- ERROR: the first HRESP=1 cycle (HREADY=0) is treated as a wait state. The second (HREADY=1) completes with rsp_err=1. A pending address phase is not cancelled and proceeds normally.
- Ordering: responses are strictly in command order; at most 2 transfers are in flight.
- busy = a_vld || d_vld.
- Reset (HRESETn=0 at edge, also mid-transfer):
  - a_vld=d_vld=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0.
  - In-flight transfers are dropped with no response.
  - cmd_ready=1 once reset is released.

Test Plan:
- Single write, HREADY=1: cmd addr=0x0001_0004, wdata=0xDEADBEEF at T -> HTRANS=NONSEQ, HADDR=0x0001_0004, HWRITE=1 in T+1; HWDATA=0xDEADBEEF in T+2; rsp_valid=1, rsp_write=1, rsp_err=0, rsp_rdata=0 in T+3.
- Single read: addr=0x0000_0010, slave HRDATA=0x12345678 in data phase -> rsp_rdata=0x12345678, rsp_write=0, rsp_valid for exactly 1 cycle.
- Back-to-back: 4 commands with cmd_valid held, alternating write/read -> cmd_ready stays 1, HTRANS=NONSEQ for 4 consecutive cycles, 4 in-order rsp_valid pulses on consecutive cycles.
- Wait states: HREADY=0 for 3 cycles during a write data phase while a read is in the address phase -> HADDR, HWRITE and HWDATA stable, cmd_ready=0, HTRANS held NONSEQ; both complete afterwards with responses 3 cycles late.
- ERROR: slave gives HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on a read -> rsp_err=1. The following command completes with rsp_err=0.
- Reset mid-transfer: HRESETn=0 while d_vld=1 and HREADY=0 -> next cycle HTRANS=IDLE, HADDR=0, busy=0, no rsp_valid. A new read after release completes normally.
